crtc_timing: RTL and testbench
==============================

Name: crtc_timing

Overview:
- Character-clock timing generator sitting directly downstream of the VGA sequencer.
- Clocked by the sequencer's character clock output; produces horizontal and vertical counters, sync pulses, display-enable/blank and a frame-start strobe for the attribute/pixel pipeline.
- Honours the sequencer's soft reset and screen-inhibit flags.
- Timing is fixed at elaboration time via parameters; default is 640x480 text/graphics in 8-dot characters.

Parameters:
- HTOTAL, 100, characters per line (counter wraps at HTOTAL-1)
- HDISP, 80, displayed characters per line
- HSYNC_START, 82, first character of hsync
- HSYNC_END, 94, first character after hsync
- VTOTAL, 525, lines per frame
- VDISP, 480, displayed lines
- VSYNC_START, 490, first line of vsync
- VSYNC_END, 492, first line after vsync
- HSYNC_POL, 0, active level of hsync_o
- VSYNC_POL, 0, active level of vsync_o

Ports:
- clock_i  in  1  character clock (vga_chrclk_o from the sequencer)
- reset_i  in  1  asynchronous, active-high reset
- softreset_i  in  1  synchronous hold; counters frozen at zero while high
- vgainhibit_i  in  1  force blanking; syncs keep running
- col_o  out  7  horizontal character counter
- row_o  out  10  vertical line counter
- hsync_o  out  1  horizontal sync, polarity per HSYNC_POL
- vsync_o  out  1  vertical sync, polarity per VSYNC_POL
- blank_o  out  1  high outside the display area or when inhibited
- de_o  out  1  display enable (~blank_o)
- frame_o  out  1  one-cycle strobe when col=0 and row=0
- vint_o  out  1  vertical interrupt flag (optional feature only; else tied 0)
- vint_clr_i  in  1  clears vint_o (optional feature only; else ignored)

Behaviour:
- Reset (async, reset_i=1):
  - col_o=0, row_o=0
  - hsync_o=~HSYNC_POL, vsync_o=~VSYNC_POL
  - blank_o=1, de_o=0, frame_o=0, vint_o=0
- Counters:
  - col increments every clock; at HTOTAL-1 it wraps to 0 and row increments.
  - row wraps to 0 when it is VTOTAL-1 and col wraps.
  - Widths as listed; parameters are required to fit (HTOTAL<=128, VTOTAL<=1024).
- Registered decodes:
  - All decoded outputs are registered from the next-state counter values, so hsync_o, vsync_o, blank_o, de_o and frame_o align with col_o/row_o in the same cycle. There is no extra latency.
- Decode rules for the current col/row:
  - hsync active iff HSYNC_START <= col < HSYNC_END.
  - vsync active iff VSYNC_START <= row < VSYNC_END. vsync changes only at col wrap.
  - blank = (col >= HDISP) | (row >= VDISP) | vgainhibit.
  - frame = (col==0 & row==0). It is not asserted on the first cycle out of reset or softreset; it is next asserted at the first wrap back to 0,0.
- vgainhibit_i:
  - Sampled each clock; affects blank_o/de_o on the following cycle.
  - Counters, syncs and frame_o are unaffected.
- softreset_i:
  - While high: counters load 0, syncs inactive, blank_o=1, frame_o=0.
  - On release: counting resumes from 0,0 on the next clock, with hsync/vsync inactive and blank_o=0 (unless inhibited).
- Simultaneous events:
  - reset_i dominates softreset_i.
  - softreset_i dominates wrap logic.
- Reset mid-frame: all outputs return immediately to their reset values; no partial pulse completion.

Optional Feature:
- Macro: CRTC_VINT_EN.
- Defined:
  - vint_o sets on the cycle row reaches VDISP with col=0, i.e. the start of the vertical blank.
  - vint_o stays set until vint_clr_i=1.
  - Set wins over a simultaneous clear.
  - Cleared by reset_i and softreset_i.
- Undefined: vint_o is constant 0, vint_clr_i is unused, and no flag register is synthesised.

Test Plan:
- Release reset_i, run 200 clocks -> col_o counts 0..99 then wraps; row_o goes 0->1 at clock 100; hsync_o low for exactly 12 clocks (col 82..93) per line.
- Run 525*100 clocks -> vsync_o low for rows 490-491 (200 clocks); blank_o=0 for exactly 80 cols on each of rows 0-479; frame_o pulses once per 52500 clocks.
- Assert vgainhibit_i at col 10, row 5 for 20 clocks -> blank_o=1 from col 11 for 20 cycles; hsync_o/vsync_o timing identical to the uninhibited run.
- Assert softreset_i at row 300, col 50 for 5 clocks -> col_o=row_o=0 and blank_o=1 during hold; after release col_o=1 on the next clock; the next frame_o pulse comes 52500 clocks after release.
- Assert reset_i asynchronously mid-hsync (col 85, row 100) -> hsync_o goes inactive without waiting for a clock edge; all outputs at reset values.
- With CRTC_VINT_EN: run to row 480 -> vint_o=1 at col 0; pulse vint_clr_i on the same cycle row wraps to 480 on the next frame -> vint_o stays 1 (set wins); clear at row 10 -> vint_o=0.

Source files
------------

// File: rtl/crtc_timing.sv
// crtc_timing: character-clock CRT timing generator (col/row counters, syncs, blank/de, frame strobe).
// Latency: every decode is registered from the next-state counters, so all outputs align with col_o/row_o.
// Backpressure: none; free-running, held at 0,0 by softreset_i. Optional vertical interrupt: CRTC_VINT_EN.
module crtc_timing #(
  parameter int   HTOTAL      = 100,
  parameter int   HDISP       = 80,
  parameter int   HSYNC_START = 82,
  parameter int   HSYNC_END   = 94,
  parameter int   VTOTAL      = 525,
  parameter int   VDISP       = 480,
  parameter int   VSYNC_START = 490,
  parameter int   VSYNC_END   = 492,
  parameter logic HSYNC_POL   = 1'b0,
  parameter logic VSYNC_POL   = 1'b0
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       softreset_i,
  input  logic       vgainhibit_i,
  input  logic       vint_clr_i,
  output logic [6:0] col_o,
  output logic [9:0] row_o,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       blank_o,
  output logic       de_o,
  output logic       frame_o,
  output logic       vint_o
);

  // Limits are one bit wider than the counters so an end value equal to the
  // total (e.g. HSYNC_END == HTOTAL == 128) still compares correctly.
  localparam logic [6:0]  H_LAST = 7'(HTOTAL - 1);
  localparam logic [9:0]  V_LAST = 10'(VTOTAL - 1);
  localparam logic [7:0]  H_DISP = 8'(HDISP);
  localparam logic [7:0]  H_SS   = 8'(HSYNC_START);
  localparam logic [7:0]  H_SE   = 8'(HSYNC_END);
  localparam logic [10:0] V_DISP = 11'(VDISP);
  localparam logic [10:0] V_SS   = 11'(VSYNC_START);
  localparam logic [10:0] V_SE   = 11'(VSYNC_END);

  logic [6:0] col_nxt;
  logic [9:0] row_nxt;
  logic [7:0] col_ext;
  logic [10:0] row_ext;
  logic       hs_act, vs_act;
  logic       hs_nxt, vs_nxt, blank_nxt, frame_nxt;

  assign col_ext = {1'b0, col_nxt};
  assign row_ext = {1'b0, row_nxt};

  // Next counter values: softreset holds at 0,0, otherwise count and wrap.
  always_comb begin
    col_nxt = col_o + 7'd1;
    row_nxt = row_o;
    if (softreset_i) begin
      col_nxt = '0;
      row_nxt = '0;
    end else if (col_o == H_LAST) begin
      col_nxt = '0;
      row_nxt = (row_o == V_LAST) ? '0 : row_o + 10'd1;
    end
  end

  // Decode the next-state position so the registered flags line up with the counters.
  always_comb begin
    hs_nxt    = !softreset_i && (col_ext >= H_SS) && (col_ext < H_SE);
    vs_nxt    = !softreset_i && (row_ext >= V_SS) && (row_ext < V_SE);
    blank_nxt = softreset_i || (col_ext >= H_DISP) || (row_ext >= V_DISP) || vgainhibit_i;
    frame_nxt = !softreset_i && (col_nxt == '0) && (row_nxt == '0);
  end

  // Counter and decoded-flag registers; reset returns everything to idle at once.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      col_o   <= '0;
      row_o   <= '0;
      hs_act  <= 1'b0;
      vs_act  <= 1'b0;
      blank_o <= 1'b1;
      frame_o <= 1'b0;
    end else begin
      col_o   <= col_nxt;
      row_o   <= row_nxt;
      hs_act  <= hs_nxt;
      vs_act  <= vs_nxt;
      blank_o <= blank_nxt;
      frame_o <= frame_nxt;
    end
  end

  assign hsync_o = hs_act ? HSYNC_POL : ~HSYNC_POL;
  assign vsync_o = vs_act ? VSYNC_POL : ~VSYNC_POL;
  assign de_o    = ~blank_o;

`ifdef CRTC_VINT_EN
  logic vint_set;
  assign vint_set = !softreset_i && (col_nxt == '0) && (row_ext == V_DISP);

  // Sticky vertical-blank interrupt; a set in the same cycle as a clear wins.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      vint_o <= 1'b0;
    end else if (softreset_i) begin
      vint_o <= 1'b0;
    end else if (vint_set) begin
      vint_o <= 1'b1;
    end else if (vint_clr_i) begin
      vint_o <= 1'b0;
    end
  end
`else
  logic unused_vint_clr;
  assign unused_vint_clr = vint_clr_i;
  assign vint_o          = 1'b0;
`endif

endmodule

// File: tb/tb_crtc_timing.sv
// Bench for crtc_timing with default 640x480 timing (HTOTAL 100, VTOTAL 525, active-low syncs).
// Table of directed vectors from reset, then hand sequences for inhibit, softreset + full frame, async reset.
// Inputs change 1 time unit after the rising edge; outputs are sampled at that same point.
module tb_crtc_timing;

  logic       clk = 1'b0;
  logic       reset_i, softreset_i, vgainhibit_i, vint_clr_i;
  logic [6:0] col_o;
  logic [9:0] row_o;
  logic       hsync_o, vsync_o, blank_o, de_o, frame_o, vint_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  crtc_timing dut (
    .clock_i      (clk),
    .reset_i      (reset_i),
    .softreset_i  (softreset_i),
    .vgainhibit_i (vgainhibit_i),
    .vint_clr_i   (vint_clr_i),
    .col_o        (col_o),
    .row_o        (row_o),
    .hsync_o      (hsync_o),
    .vsync_o      (vsync_o),
    .blank_o      (blank_o),
    .de_o         (de_o),
    .frame_o      (frame_o),
    .vint_o       (vint_o)
  );

  typedef struct {
    int   n;       // clocks to apply with these inputs before comparing
    logic sr;
    logic inh;
    int   col;
    int   row;
    logic hs;      // output level (active low)
    logic vs;
    logic blank;
    logic frame;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_col"},   32'(col_o), 0);
    check({tag, "_row"},   32'(row_o), 0);
    check({tag, "_hsync"}, 32'(hsync_o), 1);
    check({tag, "_vsync"}, 32'(vsync_o), 1);
    check({tag, "_blank"}, 32'(blank_o), 1);
    check({tag, "_de"},    32'(de_o), 0);
    check({tag, "_frame"}, 32'(frame_o), 0);
    check({tag, "_vint"},  32'(vint_o), 0);
  endtask

  initial begin
    int col_err, row_err, hs_err, vs_err, bl_err, de_err, fr_err, vi_err;
    int hs_cnt, vs_cnt, de_cnt, fr_cnt, fr_k;
    int ec, er;
    logic ehs, evs, ebl, efr, evi;

    //        n      sr inh col row hs vs bl fr
    vecs[0]  = '{1,     0, 0,  1,  0, 1, 1, 0, 0};
    vecs[1]  = '{78,    0, 0, 79,  0, 1, 1, 0, 0};
    vecs[2]  = '{1,     0, 0, 80,  0, 1, 1, 1, 0};
    vecs[3]  = '{1,     0, 0, 81,  0, 1, 1, 1, 0};
    vecs[4]  = '{1,     0, 0, 82,  0, 0, 1, 1, 0};
    vecs[5]  = '{11,    0, 0, 93,  0, 0, 1, 1, 0};
    vecs[6]  = '{1,     0, 0, 94,  0, 1, 1, 1, 0};
    vecs[7]  = '{5,     0, 0, 99,  0, 1, 1, 1, 0};
    vecs[8]  = '{1,     0, 0,  0,  1, 1, 1, 0, 0};
    vecs[9]  = '{1,     0, 1,  1,  1, 1, 1, 1, 0};
    vecs[10] = '{1,     0, 0,  2,  1, 1, 1, 0, 0};
    vecs[11] = '{3,     1, 0,  0,  0, 1, 1, 1, 0};
    vecs[12] = '{1,     0, 0,  1,  0, 1, 1, 0, 0};
    vecs[13] = '{509,   0, 0, 10,  5, 1, 1, 0, 0};

    reset_i      = 1'b1;
    softreset_i  = 1'b0;
    vgainhibit_i = 1'b0;
    vint_clr_i   = 1'b0;

    // Reset values before any clock edge, and still held across edges.
    #2;
    check_idle("rst0");
    step();
    step();
    check_idle("rst_held");
    reset_i = 1'b0;

    // Directed table from the reset state.
    for (int v = 0; v < 14; v++) begin
      softreset_i  = vecs[v].sr;
      vgainhibit_i = vecs[v].inh;
      for (int c = 0; c < vecs[v].n; c++) step();
      check($sformatf("v%0d_col", v),   32'(col_o),   32'(vecs[v].col));
      check($sformatf("v%0d_row", v),   32'(row_o),   32'(vecs[v].row));
      check($sformatf("v%0d_hsync", v), 32'(hsync_o), 32'(vecs[v].hs));
      check($sformatf("v%0d_vsync", v), 32'(vsync_o), 32'(vecs[v].vs));
      check($sformatf("v%0d_blank", v), 32'(blank_o), 32'(vecs[v].blank));
      check($sformatf("v%0d_de", v),    32'(de_o),    32'(!vecs[v].blank));
      check($sformatf("v%0d_frame", v), 32'(frame_o), 32'(vecs[v].frame));
      check($sformatf("v%0d_vint", v),  32'(vint_o),  0);
    end
    softreset_i  = 1'b0;
    vgainhibit_i = 1'b0;

    // Inhibit for 20 clocks starting at col 10 row 5: blank from col 11 to col 30.
    vgainhibit_i = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      check($sformatf("inh%0d_col", i),   32'(col_o), 32'(10 + i));
      check($sformatf("inh%0d_blank", i), 32'(blank_o), 1);
      check($sformatf("inh%0d_de", i),    32'(de_o), 0);
      check($sformatf("inh%0d_hsync", i), 32'(hsync_o), 1);
    end
    vgainhibit_i = 1'b0;
    step();
    check("inh_end_col",   32'(col_o), 31);
    check("inh_end_row",   32'(row_o), 5);
    check("inh_end_blank", 32'(blank_o), 0);
    check("inh_end_de",    32'(de_o), 1);

    // Advance to row 300 col 50, then hold softreset for 5 clocks.
    repeat (29519) step();
    check("pre_sr_col", 32'(col_o), 50);
    check("pre_sr_row", 32'(row_o), 300);
    softreset_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_idle($sformatf("sr%0d", i));
    end
    softreset_i = 1'b0;

    // Full frame after release: position follows k clocks from the last hold cycle.
    col_err = 0; row_err = 0; hs_err = 0; vs_err = 0; bl_err = 0; de_err = 0; fr_err = 0; vi_err = 0;
    hs_cnt = 0; vs_cnt = 0; de_cnt = 0; fr_cnt = 0; fr_k = -1;
    for (int k = 1; k <= 52500; k++) begin
      step();
      ec  = k % 100;
      er  = (k / 100) % 525;
      ehs = !(ec >= 82 && ec < 94);
      evs = !(er >= 490 && er < 492);
      ebl = (ec >= 80) || (er >= 480);
      efr = (k == 52500);
`ifdef CRTC_VINT_EN
      evi = (k >= 48000);
`else
      evi = 1'b0;
`endif
      if (k == 1) begin
        check("release_col",   32'(col_o), 1);
        check("release_blank", 32'(blank_o), 0);
        check("release_hsync", 32'(hsync_o), 1);
      end
      if (32'(col_o) != 32'(ec)) col_err++;
      if (32'(row_o) != 32'(er)) row_err++;
      if (hsync_o !== ehs) hs_err++;
      if (vsync_o !== evs) vs_err++;
      if (blank_o !== ebl) bl_err++;
      if (de_o !== !ebl) de_err++;
      if (frame_o !== efr) fr_err++;
      if (vint_o !== evi) vi_err++;
      if (hsync_o === 1'b0) hs_cnt++;
      if (vsync_o === 1'b0) vs_cnt++;
      if (de_o === 1'b1) de_cnt++;
      if (frame_o === 1'b1) begin
        fr_cnt++;
        if (fr_k < 0) fr_k = k;
      end
    end
    check("scan_col_errs",   32'(col_err), 0);
    check("scan_row_errs",   32'(row_err), 0);
    check("scan_hsync_errs", 32'(hs_err), 0);
    check("scan_vsync_errs", 32'(vs_err), 0);
    check("scan_blank_errs", 32'(bl_err), 0);
    check("scan_de_errs",    32'(de_err), 0);
    check("scan_frame_errs", 32'(fr_err), 0);
    check("scan_vint_errs",  32'(vi_err), 0);
    check("scan_hsync_cycles", 32'(hs_cnt), 6300);
    check("scan_vsync_cycles", 32'(vs_cnt), 200);
    check("scan_de_cycles",    32'(de_cnt), 38400);
    check("scan_frame_pulses", 32'(fr_cnt), 1);
    check("scan_frame_at",     32'(fr_k), 52500);

    // Clear pulse: flag drops (and is constant 0 without the feature).
    vint_clr_i = 1'b1;
    step();
    vint_clr_i = 1'b0;
    check("vint_clr", 32'(vint_o), 0);
    check("vint_clr_col", 32'(col_o), 1);

    // Asynchronous reset in the middle of hsync, with no clock edge in between.
    repeat (84) step();
    check("pre_arst_col",   32'(col_o), 85);
    check("pre_arst_hsync", 32'(hsync_o), 0);
    #2;
    reset_i = 1'b1;
    #1;
    check_idle("arst");
    step();
    reset_i = 1'b0;
    step();
    check("post_arst_col",   32'(col_o), 1);
    check("post_arst_frame", 32'(frame_o), 0);
    check("post_arst_blank", 32'(blank_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
